// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM bank.
//   - clog2 / pulse_width_w: constant functions used to size counters and widths
//   - DEF_*: default configuration (50 MHz clock, 128 kHz tick, 20 ms frame)
//   - ch_state_e: per-channel lifecycle (disabled -> pending -> running)
package servo_pkg;

  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_CTRL_W      = 8;
  localparam int DEF_CLK_HZ      = 50_000_000;
  localparam int DEF_TICK_HZ     = 128_000;
  localparam int DEF_FRAME_TICKS = 2560;
  localparam int DEF_MIN_TICKS   = 64;

  // Bits needed to hold 0..value-1. Never returns less than 1, so a
  // single-channel bank still gets a one-bit address port.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

  // Width of a pulse length in ticks: MIN_TICKS + active, active < 2^CTRL_W.
  function automatic int pulse_width_w(input int min_ticks, input int ctrl_w);
    return clog2(min_ticks + (1 << ctrl_w));
  endfunction

  // DISABLED: never loaded since reset; output held low.
  // PENDING : loaded, waiting for the next frame boundary to take its value.
  // RUNNING : emitting full pulses every frame.
  typedef enum logic [1:0] {
    CH_DISABLED,
    CH_PENDING,
    CH_RUNNING
  } ch_state_e;

endpackage

// File: rtl/servo_channel.sv
// One servo output: shadow setpoint, active value, slew limiter and the
// pulse comparator.
//   clock, reset_n   : system clock, async active-low reset
//   load             : valid load addressed to this channel (already decoded)
//   control          : setpoint captured into shadow on load
//   frame_update     : high on the clock edge at which the frame counter wraps
//   frame_cnt_next   : frame counter value after the coming edge
//   pwm              : registered servo pulse
module servo_channel import servo_pkg::*; #(
  parameter int CTRL_W    = 8,
  parameter int FRAME_W   = 12,
  parameter int MIN_TICKS = 64,
  parameter int SLEW_STEP = 0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [CTRL_W-1:0]  control,
  input  logic               frame_update,
  input  logic [FRAME_W-1:0] frame_cnt_next,
  output logic               pwm
);

  localparam int MAX_VAL = (1 << CTRL_W) - 1;
  // Steps larger than the setpoint range behave exactly like no limiting.
  localparam int STEP    = (SLEW_STEP > MAX_VAL) ? MAX_VAL : SLEW_STEP;
  localparam int WIDTH_W = pulse_width_w(MIN_TICKS, CTRL_W);
  localparam logic signed [CTRL_W:0] STEP_S = (CTRL_W+1)'(STEP);

  ch_state_e            state, state_next;
  logic [CTRL_W-1:0]    shadow, active, active_next;
  logic signed [CTRL_W:0] diff;
  logic [WIDTH_W-1:0]   width_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= CH_DISABLED;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      CH_DISABLED: if (load)         state_next = CH_PENDING;
      CH_PENDING:  if (frame_update) state_next = CH_RUNNING;
      default:     ;
    endcase
  end

  // Active value for the coming frame. A pending channel takes its shadow
  // directly; a running one moves toward it by at most STEP, never past it.
  always_comb begin
    diff        = $signed({1'b0, shadow}) - $signed({1'b0, active});
    active_next = active;
    if (frame_update) begin
      if (state != CH_RUNNING || STEP == 0) active_next = shadow;
      else if (diff > STEP_S)               active_next = active + CTRL_W'(STEP);
      else if (diff < -STEP_S)              active_next = active - CTRL_W'(STEP);
      else                                  active_next = shadow;
    end
    width_next = WIDTH_W'(MIN_TICKS) + WIDTH_W'(active_next);
  end

  // NOTE: shadow and active are a handful of flops per channel, not a RAM,
  // so they sit on the async reset like any other state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (load) shadow <= control;
      active <= active_next;
      // Uses post-edge counter and active value so the rising edge lands
      // on the frame-wrap edge itself.
      pwm <= (state_next == CH_RUNNING) &&
             (frame_cnt_next < FRAME_W'(width_next));
    end
  end

endmodule

// File: rtl/servo_pwm_bank.sv
// N-channel hobby-servo PWM generator. A prescaler produces a one-clock
// tick; ticks advance a frame counter shared by all channels, so every
// enabled output rises on the same edge.
//   clock, reset_n : system clock, async active-low reset
//   address        : channel targeted by load
//   control        : setpoint value
//   load           : sampled every clock; writes shadow[address]
//   pwm            : registered servo pulses, one bit per channel
//   frame_start    : one-clock pulse after the edge where the frame wraps
//   load_err       : one-clock pulse after a load to a nonexistent channel
module servo_pwm_bank import servo_pkg::*; #(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int CTRL_W      = DEF_CTRL_W,
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int TICK_HZ     = DEF_TICK_HZ,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int MIN_TICKS   = DEF_MIN_TICKS,
  parameter int SLEW_STEP   = 0,
  parameter int ADDR_W      = clog2(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [CTRL_W-1:0]   control,
  input  logic                load,
  output logic [CHANNELS-1:0] pwm,
  output logic                frame_start,
  output logic                load_err
);

  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PRE_W   = clog2(DIV);
  localparam int FRAME_W = clog2(FRAME_TICKS);
  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_TICKS - 1);
  localparam logic [ADDR_W:0]    CH_LIMIT   = (ADDR_W+1)'(CHANNELS);

  if (DIV < 2) begin : g_bad_div
    $error("servo_pwm_bank: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (MIN_TICKS + (1 << CTRL_W) - 1 >= FRAME_TICKS) begin : g_bad_frame
    $error("servo_pwm_bank: longest pulse does not fit inside the frame");
  end
  if (CHANNELS < 1 || CHANNELS > 64) begin : g_bad_channels
    $error("servo_pwm_bank: CHANNELS must be 1..64");
  end

  logic [PRE_W-1:0]   pre_cnt;
  logic [FRAME_W-1:0] frame_cnt, frame_cnt_next;
  logic               tick, frame_wrap;
  logic               addr_ok, load_valid;

  // NOTE: every signal gets a default before any branch, so no path can
  // leave one unassigned and synthesis never infers a latch.
  always_comb begin
    tick           = (pre_cnt == PRE_LAST);
    frame_wrap     = tick && (frame_cnt == FRAME_LAST);
    frame_cnt_next = frame_cnt;
    if (frame_wrap) frame_cnt_next = '0;
    else if (tick)  frame_cnt_next = frame_cnt + FRAME_W'(1);
  end

  // Address widths are powers of two, so non-power-of-two banks need an
  // explicit range check.
  assign addr_ok    = ({1'b0, address} < CH_LIMIT);
  assign load_valid = load && addr_ok;

  // NOTE: non-blocking assignments make every register here sample the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt     <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      pre_cnt     <= tick ? '0 : pre_cnt + PRE_W'(1);
      frame_cnt   <= frame_cnt_next;
      frame_start <= frame_wrap;
      load_err    <= load && !addr_ok;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    servo_channel #(
      .CTRL_W    (CTRL_W),
      .FRAME_W   (FRAME_W),
      .MIN_TICKS (MIN_TICKS),
      .SLEW_STEP (SLEW_STEP)
    ) u_channel (
      .clock          (clock),
      .reset_n        (reset_n),
      .load           (load_valid && (address == ADDR_W'(i))),
      .control        (control),
      .frame_update   (frame_wrap),
      .frame_cnt_next (frame_cnt_next),
      .pwm            (pwm[i])
    );
  end

endmodule
